// File: rtl/axi_mem_pkg.sv
// Shared constants and state types for the AXI4 on-chip memory responder.
package axi_mem_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;

  typedef enum logic {
    RIdle,
    RBurst
  } r_state_e;

  typedef enum logic [1:0] {
    WIdle,
    WData,
    WResp
  } w_state_e;

endpackage

// File: rtl/axi_mem_ram.sv
// Simple dual-port RAM: byte-enabled write port, registered read port with enable.
// A read and a write to the same word in one cycle return the old contents.
module axi_mem_ram #(
  parameter int unsigned DataWidth = 128,
  parameter int unsigned Depth     = 4096,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 wr_en_i,
  input  logic [AddrWidth-1:0] wr_addr_i,
  input  logic [DataWidth-1:0] wr_data_i,
  input  logic [StrbWidth-1:0] wr_strb_i,
  input  logic                 rd_en_i,
  input  logic [AddrWidth-1:0] rd_addr_i,
  output logic [DataWidth-1:0] rd_data_o
);

  logic [DataWidth-1:0] mem_q [Depth];
  logic [DataWidth-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      for (int i = 0; i < int'(StrbWidth); i++) begin
        if (wr_strb_i[i]) begin
          mem_q[wr_addr_i][i*8 +: 8] <= wr_data_i[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by on-chip RAM, with independent read and write burst engines.
// Used as scratch memory and as the loopback memory behind the DMA masters.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 128,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           ID_WIDTH   = 6,
  parameter int unsigned           STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned           DEPTH      = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_WIDTH-1:0]   s_axi_arid,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_WIDTH-1:0]   s_axi_rid,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int unsigned OffW      = $clog2(STRB_WIDTH);
  localparam int unsigned RamAw     = $clog2(DEPTH);
  localparam int unsigned SpanBytes = DEPTH * STRB_WIDTH;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] a, lo, hi;
    a  = {1'b0, addr};
    lo = {1'b0, BASE_ADDR};
    hi = lo + (ADDR_WIDTH+1)'(SpanBytes);
    return (a >= lo) && (a < hi);
  endfunction

  // Only INCR/FIXED at full bus width are served; anything else fails the whole burst.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return !((burst == BurstIncr) || (burst == BurstFixed)) || (size != 3'(OffW));
  endfunction

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  r_state_e              r_state_q, r_state_d;
  logic                  ar_ready_q;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q;
  logic                  r_fixed_q;
  logic                  r_err_q;
  logic [8:0]            r_idx_q;
  logic                  s1_valid_q;
  logic [1:0]            s1_resp_q;
  logic                  s1_last_q;
  logic                  rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  logic                  ar_hs, r_out_free, r_fetch, r_beat_ok, r_done, s1_pop;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] r_off;
  logic [DATA_WIDTH-1:0] ram_rd_data;

  assign ar_hs      = s_axi_arvalid && ar_ready_q;
  assign r_out_free = !rvalid_q || s_axi_rready;
  assign s1_pop     = s1_valid_q && r_out_free;
  assign r_beat_ok  = in_range(r_addr_q);
  assign r_done     = rvalid_q && s_axi_rready && rlast_q;
  // The RAM output register is the first pipeline stage; only refill it once it drains.
  assign r_fetch    = (r_state_q == RBurst) && (r_idx_q <= {1'b0, r_len_q}) &&
                      (!s1_valid_q || r_out_free);
  assign ram_rd_en  = r_fetch && !r_err_q && r_beat_ok;
  assign r_off      = r_addr_q - BASE_ADDR;

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_hs)  r_state_d = RBurst;
      RBurst:  if (r_done) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q  <= RIdle;
      ar_ready_q <= 1'b0;
      r_id_q     <= '0;
      r_addr_q   <= '0;
      r_len_q    <= '0;
      r_fixed_q  <= 1'b0;
      r_err_q    <= 1'b0;
      r_idx_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_resp_q  <= RespOkay;
      s1_last_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
      rlast_q    <= 1'b0;
    end else begin
      r_state_q  <= r_state_d;
      ar_ready_q <= (r_state_d == RIdle);

      if (ar_hs) begin
        r_id_q    <= s_axi_arid;
        r_addr_q  <= s_axi_araddr;
        r_len_q   <= s_axi_arlen;
        r_fixed_q <= (s_axi_arburst == BurstFixed);
        r_err_q   <= burst_bad(s_axi_arburst, s_axi_arsize);
        r_idx_q   <= '0;
      end else if (r_fetch) begin
        r_idx_q <= r_idx_q + 9'd1;
        if (!r_fixed_q) r_addr_q <= r_addr_q + ADDR_WIDTH'(STRB_WIDTH);
      end

      if (r_fetch) begin
        s1_valid_q <= 1'b1;
        s1_resp_q  <= r_err_q ? RespSlverr : (r_beat_ok ? RespOkay : RespDecerr);
        s1_last_q  <= (r_idx_q == {1'b0, r_len_q});
      end else if (s1_pop) begin
        s1_valid_q <= 1'b0;
      end

      if (s1_pop) begin
        rvalid_q <= 1'b1;
        rdata_q  <= (s1_resp_q == RespOkay) ? ram_rd_data : '0;
        rresp_q  <= s1_resp_q;
        rlast_q  <= s1_last_q;
      end else if (r_out_free) begin
        rvalid_q <= 1'b0;
        rlast_q  <= 1'b0;
      end
    end
  end

  assign s_axi_arready = ar_ready_q;
  assign s_axi_rid     = r_id_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rvalid  = rvalid_q;

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  w_state_e              w_state_q, w_state_d;
  logic                  aw_ready_q, w_ready_q, b_valid_q;
  logic [ID_WIDTH-1:0]   b_id_q;
  logic [1:0]            b_resp_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q;
  logic                  w_fixed_q;
  logic                  w_err_q;
  logic                  w_dec_q;
  logic [8:0]            w_idx_q;

  logic                  aw_hs, w_hs, b_hs, w_beat_ok, ram_wr_en;
  logic [ADDR_WIDTH-1:0] w_off;

  assign aw_hs     = s_axi_awvalid && aw_ready_q;
  assign w_hs      = s_axi_wvalid && w_ready_q;
  assign b_hs      = b_valid_q && s_axi_bready;
  assign w_beat_ok = in_range(w_addr_q);
  assign ram_wr_en = w_hs && (w_idx_q <= {1'b0, w_len_q}) && !w_err_q && w_beat_ok;
  assign w_off     = w_addr_q - BASE_ADDR;

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_hs)               w_state_d = WData;
      WData:   if (w_hs && s_axi_wlast) w_state_d = WResp;
      WResp:   if (b_hs)                w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q  <= WIdle;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_id_q     <= '0;
      b_resp_q   <= RespOkay;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_fixed_q  <= 1'b0;
      w_err_q    <= 1'b0;
      w_dec_q    <= 1'b0;
      w_idx_q    <= '0;
    end else begin
      w_state_q  <= w_state_d;
      aw_ready_q <= (w_state_d == WIdle);
      w_ready_q  <= (w_state_d == WData);
      b_valid_q  <= (w_state_d == WResp);

      if (aw_hs) begin
        b_id_q    <= s_axi_awid;
        w_addr_q  <= s_axi_awaddr;
        w_len_q   <= s_axi_awlen;
        w_fixed_q <= (s_axi_awburst == BurstFixed);
        w_err_q   <= burst_bad(s_axi_awburst, s_axi_awsize);
        w_dec_q   <= 1'b0;
        w_idx_q   <= '0;
      end else if (w_hs) begin
        // Saturate so an overlong burst never wraps back into the writable range.
        if (!w_idx_q[8]) w_idx_q <= w_idx_q + 9'd1;
        if (!w_fixed_q)  w_addr_q <= w_addr_q + ADDR_WIDTH'(STRB_WIDTH);
        if (!w_beat_ok)  w_dec_q <= 1'b1;
      end

      if (w_hs && s_axi_wlast) begin
        if (w_err_q || (w_idx_q != {1'b0, w_len_q})) begin
          b_resp_q <= RespSlverr;
        end else if (w_dec_q || !w_beat_ok) begin
          b_resp_q <= RespDecerr;
        end else begin
          b_resp_q <= RespOkay;
        end
      end
    end
  end

  assign s_axi_awready = aw_ready_q;
  assign s_axi_wready  = w_ready_q;
  assign s_axi_bvalid  = b_valid_q;
  assign s_axi_bid     = b_id_q;
  assign s_axi_bresp   = b_resp_q;

  axi_mem_ram #(
    .DataWidth (DATA_WIDTH),
    .Depth     (DEPTH)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (w_off[OffW +: RamAw]),
    .wr_data_i (s_axi_wdata),
    .wr_strb_i (s_axi_wstrb),
    .rd_en_i   (ram_rd_en),
    .rd_addr_i (r_off[OffW +: RamAw]),
    .rd_data_o (ram_rd_data)
  );

  logic unused_sigs;
  assign unused_sigs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, r_off, w_off};

endmodule
